dm_lsu_param: RTL and testbench

- Parametrised data memory with an integrated load/store lane unit.
- Accepts one word, half or byte load/store per cycle through a valid/ready request port.
- Generates byte enables internally. Sign- or zero-extends load data. Flags misaligned and out-of-range accesses.
- Clears its array after reset with a one-word-per-cycle sweep. Sits in the MEM stage in place of the fixed 4096-word memory.

---
 rtl/dm_lsu_param_pkg.sv | 38 +++
 rtl/dm_lsu_param_if.sv | 25 ++
 rtl/dm_lsu_param_lane_align.sv | 55 +++++
 rtl/dm_lsu_param.sv | 102 ++++++++++
 tb/tb_dm_lsu_param.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dm_lsu_param_pkg.sv
// Shared types for the parametrised data memory / load-store lane unit.
package dm_lsu_param_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    function automatic size_e op_size(input op_e op);
        case (op)
            OP_LW, OP_SW:         return SIZE_WORD;
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            default:              return SIZE_BYTE;
        endcase
    endfunction

    function automatic logic op_is_store(input op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/dm_lsu_param_if.sv
// Request/response port of the data memory: one request per cycle in, one pulse response out.
interface dm_lsu_param_if;
    import dm_lsu_param_pkg::*;

    logic        req_valid;
    logic        req_ready;
    op_e         req_op;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [31:0] PC;
    logic        resp_valid;
    logic        resp_exc;
    logic [31:0] RD;

    modport master (
        output req_valid, req_op, Addr, WD, PC,
        input  req_ready, resp_valid, resp_exc, RD
    );

    modport slave (
        input  req_valid, req_op, Addr, WD, PC,
        output req_ready, resp_valid, resp_exc, RD
    );

endinterface

// File: rtl/dm_lsu_param_lane_align.sv
// Combinational lane logic: byte enables, store replication, misalign check, load extension.
module dm_lane_align
    import dm_lsu_param_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic [31:0] ld_data_o
);

    size_e       size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign size     = op_size(op_i);
    assign byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    assign half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = wd_i;
        misalign_o = ((size == SIZE_WORD) && (lane_i != 2'b00)) ||
                     ((size == SIZE_HALF) && lane_i[0]);
        if (op_is_store(op_i)) begin
            case (size)
                SIZE_WORD: be_o = 4'b1111;
                SIZE_HALF: begin
                    be_o    = 4'b0011 << lane_i;
                    wdata_o = {2{wd_i[15:0]}};
                end
                default: begin
                    be_o    = 4'b0001 << lane_i;
                    wdata_o = {4{wd_i[7:0]}};
                end
            endcase
        end
    end

    always_comb begin
        ld_data_o = 32'h0;
        case (op_i)
            OP_LW:   ld_data_o = rword_i;
            OP_LH:   ld_data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_data_o = {16'h0, half_sel};
            OP_LB:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_data_o = {24'h0, byte_sel};
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_lsu_param.sv
// MEM-stage data memory: array, post-reset clear sweep and registered single-cycle response.
module dm_lsu_param
    import dm_lsu_param_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          LOG_EN    = 1'b1
) (
    input logic           Clk,
    input logic           Reset,
    dm_lsu_param_if.slave bus
);

    localparam int          DEPTH = 2 ** ADDR_W;
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [31:0]         mem_q [DEPTH];
    logic                resp_valid_q, resp_exc_q;
    logic [31:0]         rd_q;

    logic [31:0]         off;
    logic [ADDR_W-1:0]   widx;
    logic [1:0]          lane;
    logic                oor, misalign, exc, is_store, accept, wr_en;
    logic [31:0]         rword, wdata, merged, ld_data;
    logic [3:0]          be;

    // Unsigned compare so addresses below BASE_ADDR wrap to huge offsets and trap.
    assign off      = bus.Addr - BASE_ADDR;
    assign widx     = off[ADDR_W+1:2];
    assign lane     = off[1:0];
    assign oor      = {1'b0, off} >= LIMIT;
    assign exc      = misalign || oor;
    assign is_store = op_is_store(bus.req_op);
    assign accept   = bus.req_valid && bus.req_ready;
    assign wr_en    = accept && is_store && !exc;
    assign rword    = mem_q[widx];

    dm_lane_align u_align (
        .op_i       (bus.req_op),
        .lane_i     (lane),
        .wd_i       (bus.WD),
        .rword_i    (rword),
        .be_o       (be),
        .wdata_o    (wdata),
        .misalign_o (misalign),
        .ld_data_o  (ld_data)
    );

    for (genvar b = 0; b < 4; b++) begin : g_merge
        assign merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : rword[8*b +: 8];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_exc_q   <= 1'b0;
            rd_q         <= 32'h0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            resp_valid_q <= accept;
            resp_exc_q   <= accept && exc;
            rd_q         <= (accept && !exc && !is_store) ? ld_data : 32'h0;
        end
    end

    always_ff @(posedge Clk) begin
        if (state_q == ST_CLEAR) mem_q[ptr_q] <= 32'h0;
        else if (wr_en)          mem_q[widx]  <= merged;
    end

`ifndef SYNTHESIS
    always @(posedge Clk) begin
        if (LOG_EN && wr_en)
            $display("%d@%h: *%h <= %h", $time, bus.PC, {bus.Addr[31:2], 2'b00}, merged);
    end
`endif

    // Ready is masked by Reset so a request presented alongside Reset is never accepted.
    assign bus.req_ready  = (state_q == ST_IDLE) && !Reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_exc   = resp_exc_q;
    assign bus.RD         = rd_q;

endmodule

// File: tb/tb_dm_lsu_param.sv
// Directed bench for dm_lsu_param: two instances (BASE_ADDR 0 and 0x1000), DEPTH 16.
module tb_dm_lsu_param;
    import dm_lsu_param_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    dm_lsu_param_if if0 ();
    dm_lsu_param_if if1 ();

    dm_lsu_param #(.ADDR_W(4), .BASE_ADDR(32'h0000_0000), .LOG_EN(1'b1)) u0 (
        .Clk(Clk), .Reset(Reset), .bus(if0.slave));
    dm_lsu_param #(.ADDR_W(4), .BASE_ADDR(32'h0000_1000), .LOG_EN(1'b0)) u1 (
        .Clk(Clk), .Reset(Reset), .bus(if1.slave));

    int          ntests = 0;
    int          nfail  = 0;
    logic [33:0] got;
    int          cnt;

    // One cycle: drive at negedge, sample {resp_valid, resp_exc, RD} 1ns after the accept edge.
    task automatic step(input int sel, input logic v, input op_e op, input logic [31:0] a,
                        input logic [31:0] wd, output logic [33:0] r);
        @(negedge Clk);
        if0.req_valid = v && (sel == 0);
        if1.req_valid = v && (sel == 1);
        if0.req_op = op;   if1.req_op = op;
        if0.Addr   = a;    if1.Addr   = a;
        if0.WD     = wd;   if1.WD     = wd;
        if0.PC     = 32'h0000_0400 + a;
        if1.PC     = 32'h0000_0400 + a;
        @(posedge Clk);
        #1;
        r = (sel == 0) ? {if0.resp_valid, if0.resp_exc, if0.RD}
                       : {if1.resp_valid, if1.resp_exc, if1.RD};
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        if0.req_valid = 1'b0;
        if1.req_valid = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic count_sweep(input int sel, output int n);
        if0.req_valid = 1'b0;
        if1.req_valid = 1'b0;
        n = 0;
        while (n < 100 && !((sel == 0) ? if0.req_ready : if1.req_ready)) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        if0.req_valid = 1'b0;
        if1.req_valid = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        ntests++;
        if ({if0.req_ready, if0.resp_valid, if0.resp_exc, if0.RD} !== 35'h0) begin
            nfail++;
            $display("FAIL reset_outputs: got rdy/vld/exc/rd=%h expected 0",
                     {if0.req_ready, if0.resp_valid, if0.resp_exc, if0.RD});
        end
        Reset = 1'b0;
        count_sweep(0, cnt);
        ntests++;
        if (cnt !== 16) begin nfail++; $display("FAIL sweep_len: got %0d expected 16", cnt); end
        ntests++;
        if (if1.req_ready !== 1'b1) begin nfail++; $display("FAIL sweep_u1_ready: got %b expected 1", if1.req_ready); end
        step(0, 1'b1, OP_LW, 32'h3C, 32'h0, got);
        ntests++;
        if (got !== {2'b10, 32'h0}) begin nfail++; $display("FAIL lw_cleared: got %h expected %h", got, {2'b10, 32'h0}); end
        step(0, 1'b0, OP_LW, 32'h3C, 32'h0, got);
        ntests++;
        if (got !== 34'h0) begin nfail++; $display("FAIL resp_pulse_end: got %h expected 0", got); end
    endtask

    task automatic test_not_ready();
        do_reset();
        step(0, 1'b1, OP_SW, 32'h00, 32'hFFFF_FFFF, got);
        ntests++;
        if (got !== 34'h0) begin nfail++; $display("FAIL not_ready_resp: got %h expected 0", got); end
        count_sweep(0, cnt);
        ntests++;
        if (cnt >= 100) begin nfail++; $display("FAIL not_ready_timeout: got %0d cycles expected <100", cnt); end
        step(0, 1'b1, OP_LW, 32'h00, 32'h0, got);
        ntests++;
        if (got !== {2'b10, 32'h0}) begin nfail++; $display("FAIL not_ready_ignored: got %h expected %h", got, {2'b10, 32'h0}); end
    endtask

    task automatic test_store_merge();
        step(0, 1'b1, OP_SW, 32'h10, 32'h8899_AABB, got);
        ntests++;
        if (got !== {2'b10, 32'h0}) begin nfail++; $display("FAIL sw_resp: got %h expected %h", got, {2'b10, 32'h0}); end
        step(0, 1'b1, OP_SB, 32'h11, 32'h0000_0077, got);
        ntests++;
        if (got !== {2'b10, 32'h0}) begin nfail++; $display("FAIL sb_resp: got %h expected %h", got, {2'b10, 32'h0}); end
        step(0, 1'b1, OP_LW, 32'h10, 32'h0, got);
        ntests++;
        if (got !== {2'b10, 32'h8899_77BB}) begin nfail++; $display("FAIL sb_merge: got %h expected %h", got, {2'b10, 32'h8899_77BB}); end
        step(0, 1'b1, OP_SH, 32'h12, 32'hAAAA_1234, got);
        step(0, 1'b1, OP_LW, 32'h10, 32'h0, got);
        ntests++;
        if (got !== {2'b10, 32'h1234_77BB}) begin nfail++; $display("FAIL sh_merge: got %h expected %h", got, {2'b10, 32'h1234_77BB}); end
    endtask

    task automatic test_load_ext();
        op_e         ops  [7] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_LH};
        logic [31:0] adr  [7] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h13, 32'h11, 32'h10};
        logic [31:0] exps [7] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_80F0, 32'h0000_80F0,
                                  32'hFFFF_FF80, 32'h0000_007F, 32'h0000_7F81};
        step(0, 1'b1, OP_SW, 32'h10, 32'h80F0_7F81, got);
        for (int i = 0; i < 7; i++) begin
            step(0, 1'b1, ops[i], adr[i], 32'h0, got);
            ntests++;
            if (got !== {2'b10, exps[i]}) begin
                nfail++;
                $display("FAIL load_ext[%0d]: got %h expected %h", i, got, {2'b10, exps[i]});
            end
        end
    endtask

    task automatic test_exceptions();
        op_e         ops [4] = '{OP_LW, OP_SH, OP_SW, OP_SB};
        logic [31:0] adr [4] = '{32'h02, 32'h03, 32'h40, 32'h7F};
        step(0, 1'b1, OP_SW, 32'h00, 32'hCAFE_F00D, got);
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, ops[i], adr[i], 32'h1111_1111, got);
            ntests++;
            if (got !== {2'b11, 32'h0}) begin
                nfail++;
                $display("FAIL exc[%0d]: got %h expected %h", i, got, {2'b11, 32'h0});
            end
        end
        step(0, 1'b1, OP_LW, 32'h00, 32'h0, got);
        ntests++;
        if (got !== {2'b10, 32'hCAFE_F00D}) begin nfail++; $display("FAIL exc_no_write: got %h expected %h", got, {2'b10, 32'hCAFE_F00D}); end
        step(0, 1'b1, OP_LH, 32'h02, 32'h0, got);
        ntests++;
        if (got !== {2'b10, 32'hFFFF_CAFE}) begin nfail++; $display("FAIL lh_upper: got %h expected %h", got, {2'b10, 32'hFFFF_CAFE}); end
    endtask

    task automatic test_base_addr();
        logic [31:0] adr [4] = '{32'h0FFC, 32'h0004, 32'h1040, 32'h103C};
        logic [33:0] exps[4] = '{{2'b11, 32'h0}, {2'b11, 32'h0}, {2'b11, 32'h0}, {2'b10, 32'h0}};
        step(1, 1'b1, OP_SW, 32'h1004, 32'h1234_5678, got);
        step(1, 1'b1, OP_LW, 32'h1004, 32'h0, got);
        ntests++;
        if (got !== {2'b10, 32'h1234_5678}) begin nfail++; $display("FAIL base_lw: got %h expected %h", got, {2'b10, 32'h1234_5678}); end
        for (int i = 0; i < 4; i++) begin
            step(1, 1'b1, OP_LW, adr[i], 32'h0, got);
            ntests++;
            if (got !== exps[i]) begin
                nfail++;
                $display("FAIL base_range[%0d]: got %h expected %h", i, got, exps[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1'b1, OP_SW, 32'h20, 32'hDEAD_BEEF, got);
        step(0, 1'b1, OP_LW, 32'h20, 32'h0, got);
        ntests++;
        if (got !== {2'b10, 32'hDEAD_BEEF}) begin nfail++; $display("FAIL back_to_back: got %h expected %h", got, {2'b10, 32'hDEAD_BEEF}); end
        Reset = 1'b1;
        step(0, 1'b1, OP_LW, 32'h20, 32'h0, got);
        ntests++;
        if (got !== 34'h0) begin nfail++; $display("FAIL reset_drop: got %h expected 0", got); end
        if0.req_valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        count_sweep(0, cnt);
        ntests++;
        if (cnt !== 16) begin nfail++; $display("FAIL mid_sweep_restart: got %0d expected 16", cnt); end
        step(0, 1'b1, OP_LW, 32'h20, 32'h0, got);
        ntests++;
        if (got !== {2'b10, 32'h0}) begin nfail++; $display("FAIL reset_clears: got %h expected %h", got, {2'b10, 32'h0}); end
    endtask

    initial begin
        test_reset();
        test_not_ready();
        test_store_merge();
        test_load_ext();
        test_exceptions();
        test_base_addr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
